sat_assignment_search: RTL and testbench
========================================

# sat_assignment_search

Sequential search controller that drives candidate variable assignments into the combinational 3SAT evaluator (the PLA) and samples its satisfied output. It enumerates all 2^N assignments in ascending binary order and stops on the first one the evaluator reports as satisfying. It then holds that solution and, on request, resumes the search for the next one. It sits between the host/top-level control and the PLA: it is the producer of the PLA's `inputs` vector and the consumer of its `out` bit.

## Interface
- `N`, default 3: number of formula variables; width of the assignment vector.
- `LAT`, default 0: evaluator latency in cycles (0 = purely combinational PLA; >0 when the PLA output is registered).

- `clk`  in  1  system clock, all state updates on rising edge.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `start`  in  1  begin a fresh search from assignment 0.
- `next`  in  1  from FOUND, resume search at solution+1.
- `abort`  in  1  cancel any activity, return to IDLE.
- `sat_in`  in  1  evaluator result for `assign_out` (PLA `out`).
- `assign_out`  out  N  candidate assignment to evaluator (PLA `inputs`).
- `busy`  out  1  search in progress.
- `done`  out  1  search has terminated (found or exhausted), level.
- `found`  out  1  terminated with a satisfying assignment.
- `solution`  out  N  last satisfying assignment.
- `tried`  out  N+1  candidates fully evaluated since last `start`.

## Operation
- States: IDLE, SEARCH, FOUND, EXHAUSTED.
- Reset (`rst_n`=0 at an edge): state IDLE. `assign_out`, `busy`, `done`, `found`, `solution` and `tried` are all 0. Reset overrides everything, including mid-search.
- Command priority, evaluated each edge: `abort` > `start` > `next`.
- IDLE: `start` -> SEARCH with candidate=0, wait=0, `tried`=0, `solution`=0. `next` is ignored.
- SEARCH: `assign_out`=candidate, `busy`=1.
  - wait increments each cycle until it equals LAT. The cycle with wait==LAT is the sample cycle.
  - Sample cycle with `sat_in`=1: `tried`+1, `solution`<=candidate, go to FOUND.
  - Sample cycle with `sat_in`=0 and candidate==2^N-1: `tried`+1, go to EXHAUSTED.
  - Sample cycle, otherwise: `tried`+1, candidate+1, wait=0, stay in SEARCH.
  - `start` and `next` are ignored in SEARCH.
- FOUND: `done`=1, `found`=1, `busy`=0, `assign_out` holds `solution`.
  - `next` with solution<2^N-1 -> SEARCH at solution+1, wait=0. `tried` is kept.
  - `next` with solution==2^N-1 -> EXHAUSTED next cycle, `tried` unchanged.
  - `start` -> fresh search, as from IDLE.
- EXHAUSTED: `done`=1, `found`=0, `busy`=0, `assign_out`=0. `solution` keeps its last found value. `start` -> fresh search. `next` is ignored.
- `abort` in any state -> IDLE next cycle. `busy`, `done`, `found` and `assign_out` go to 0. `solution` and `tried` are frozen.
- Arithmetic: candidate is N bits. The increment never wraps, because the max case is handled explicitly. `tried` is N+1 bits and reaches exactly 2^N on a full sweep.

## Timing
- All outputs are registered or decoded from registered state. No combinational path from `sat_in` to any output.
- Per-candidate cost: LAT+1 cycles. `assign_out` is stable for all of them; `sat_in` is sampled only in the last one.
- `start` at edge k: `busy`=1 from cycle k+1. A solution at index i raises `done`/`found` at cycle k+1+(i+1)(LAT+1), and `busy` falls in the same cycle.
- Full unsatisfiable sweep: `busy` is high for 2^N(LAT+1) cycles.
- `next` at edge j in FOUND: `busy`=1 from cycle j+1, `done`/`found` low from cycle j+1.
- `start`/`next` pulses of more than one cycle are legal. Only edges where the state accepts the command act.

## Test plan
- N=3, LAT=0, `sat_in`=(`assign_out`==5). Pulse `start` -> `busy` high 6 cycles, then `done`=1, `found`=1, `solution`=5, `tried`=6.
- Continue the previous case with a `next` pulse -> 2 busy cycles (candidates 6, 7), then EXHAUSTED: `done`=1, `found`=0, `solution`=5, `tried`=8.
- N=3, LAT=2, evaluator model with 2-cycle delay, target 5 -> `busy` for 18 cycles, `found`=1, `solution`=5. Repeat with the model delayed 3 cycles (mismatched) -> target is missed; check that sampling happens only on the wait==LAT cycle.
- N=3, LAT=0, `sat_in`=0 -> `done` after exactly 8 busy cycles, `found`=0, `tried`=8. Target 7, then `next` -> EXHAUSTED one cycle later, `tried`=8.
- `abort` at cycle 3 of a search -> IDLE next cycle, `assign_out`=0, `done`=0, `tried`=3. A subsequent `start` restarts from 0 with `tried`=0.
- Reset:
  - `rst_n`=0 mid-SEARCH -> all outputs 0 on the next edge.
  - `start` during SEARCH is ignored: candidate sequence unbroken.
  - `start` and `abort` in the same cycle -> IDLE.

Source files
------------

// File: rtl/sat_assignment_search_if.sv
`default_nettype none
// ============================================================================
// Interface     : sat_assignment_search_if
// Description   : Command / evaluator / status bundle for the SAT assignment
//                 search controller.
//                 master : host side, drives commands and the evaluator
//                          result, observes candidate and status.
//                 slave  : the search controller itself.
// Signals       : start, next, abort   - host commands
//                 sat_in                - evaluator result for assign_out
//                 assign_out [N-1:0]    - candidate driven to the evaluator
//                 busy, done, found     - status levels
//                 solution [N-1:0]      - last satisfying assignment
//                 tried [N:0]           - candidates evaluated since start
// Revision      : 1.0 - initial release
// ============================================================================
interface sat_assignment_search_if #(
  parameter int N = 3
);
  logic         start;
  logic         next;
  logic         abort;
  logic         sat_in;
  logic [N-1:0] assign_out;
  logic         busy;
  logic         done;
  logic         found;
  logic [N-1:0] solution;
  logic [N:0]   tried;

  modport master (
    output start, next, abort, sat_in,
    input  assign_out, busy, done, found, solution, tried
  );

  modport slave (
    input  start, next, abort, sat_in,
    output assign_out, busy, done, found, solution, tried
  );
endinterface
`default_nettype wire

// File: rtl/sat_assignment_search.sv
`default_nettype none
// ============================================================================
// Module        : sat_assignment_search
// Description   : Enumerates all 2^N variable assignments in ascending order,
//                 presenting each to a 3SAT evaluator for LAT+1 cycles and
//                 sampling its result on the last of them. Stops on the first
//                 satisfying assignment, holds it, and resumes from
//                 solution+1 on request.
// Ports         : clk   - system clock, rising edge
//                 rst_n - synchronous active-low reset
//                 bus   - sat_assignment_search_if.slave (commands, evaluator
//                         handshake and status outputs)
// Parameters    : N   - number of formula variables
//                 LAT - evaluator latency in cycles
// Revision      : 1.0 - initial release
// ============================================================================
module sat_assignment_search #(
  parameter int N   = 3,
  parameter int LAT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sat_assignment_search_if.slave  bus
);

  // Wait counter must hold 0..LAT; keep at least one bit when LAT is 0.
  localparam int               c_WW        = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [c_WW-1:0]  c_LAT       = c_WW'(LAT);
  localparam logic [c_WW-1:0]  c_WAIT_ONE  = c_WW'(1);
  localparam logic [N-1:0]     c_CAND_MAX  = '1;
  localparam logic [N-1:0]     c_CAND_ONE  = N'(1);
  localparam logic [N:0]       c_TRIED_ONE = (N + 1)'(1);

  localparam logic [1:0] c_S_IDLE      = 2'd0;
  localparam logic [1:0] c_S_SEARCH    = 2'd1;
  localparam logic [1:0] c_S_FOUND     = 2'd2;
  localparam logic [1:0] c_S_EXHAUSTED = 2'd3;

  logic [1:0]      r_state,    w_state_nxt;
  logic [N-1:0]    r_cand,     w_cand_nxt;
  logic [c_WW-1:0] r_wait,     w_wait_nxt;
  logic [N-1:0]    r_solution, w_solution_nxt;
  logic [N:0]      r_tried,    w_tried_nxt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= c_S_IDLE;
      r_cand     <= '0;
      r_wait     <= '0;
      r_solution <= '0;
      r_tried    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cand     <= w_cand_nxt;
      r_wait     <= w_wait_nxt;
      r_solution <= w_solution_nxt;
      r_tried    <= w_tried_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Command priority: abort > start > next.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_cand_nxt     = r_cand;
    w_wait_nxt     = r_wait;
    w_solution_nxt = r_solution;
    w_tried_nxt    = r_tried;

    if (bus.abort) begin
      // solution and tried stay frozen for inspection after an abort
      w_state_nxt = c_S_IDLE;
      w_cand_nxt  = '0;
      w_wait_nxt  = '0;
    end else begin
      case (r_state)
        c_S_IDLE, c_S_EXHAUSTED: begin
          if (bus.start) begin
            w_state_nxt    = c_S_SEARCH;
            w_cand_nxt     = '0;
            w_wait_nxt     = '0;
            w_solution_nxt = '0;
            w_tried_nxt    = '0;
          end
        end

        c_S_SEARCH: begin
          if (r_wait == c_LAT) begin
            // Sample cycle: the evaluator output now reflects r_cand.
            w_tried_nxt = r_tried + c_TRIED_ONE;
            if (bus.sat_in) begin
              w_state_nxt    = c_S_FOUND;
              w_solution_nxt = r_cand;
            end else if (r_cand == c_CAND_MAX) begin
              w_state_nxt = c_S_EXHAUSTED;
            end else begin
              w_cand_nxt = r_cand + c_CAND_ONE;
              w_wait_nxt = '0;
            end
          end else begin
            w_wait_nxt = r_wait + c_WAIT_ONE;
          end
        end

        c_S_FOUND: begin
          if (bus.start) begin
            w_state_nxt    = c_S_SEARCH;
            w_cand_nxt     = '0;
            w_wait_nxt     = '0;
            w_solution_nxt = '0;
            w_tried_nxt    = '0;
          end else if (bus.next) begin
            // The last assignment has no successor; avoid wrapping to 0.
            if (r_solution == c_CAND_MAX) begin
              w_state_nxt = c_S_EXHAUSTED;
            end else begin
              w_state_nxt = c_S_SEARCH;
              w_cand_nxt  = r_solution + c_CAND_ONE;
              w_wait_nxt  = '0;
            end
          end
        end

        default: begin
          w_state_nxt = c_S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode, purely from registered state (no path from sat_in).
  // --------------------------------------------------------------------------
  always_comb begin
    bus.assign_out = '0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.found      = 1'b0;
    case (r_state)
      c_S_SEARCH: begin
        bus.assign_out = r_cand;
        bus.busy       = 1'b1;
      end
      c_S_FOUND: begin
        bus.assign_out = r_solution;
        bus.done       = 1'b1;
        bus.found      = 1'b1;
      end
      c_S_EXHAUSTED: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.assign_out = '0;
      end
    endcase
  end

  assign bus.solution = r_solution;
  assign bus.tried    = r_tried;

endmodule
`default_nettype wire

// File: tb/tb_sat_assignment_search.sv
`default_nettype none
// ============================================================================
// Module        : tb_sat_assignment_search
// Description   : Scoreboard bench for sat_assignment_search. Two instances
//                 (LAT=0 with a combinational evaluator model, LAT=2 with a
//                 delay-line evaluator model). Each expected termination /
//                 idle event is queued before its stimulus; a monitor pops and
//                 compares whenever a DUT drops to a non-busy status change.
// Revision      : 1.0 - initial release
// ============================================================================
module tb_sat_assignment_search;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sat_assignment_search_if #(.N(3)) bus0 ();
  sat_assignment_search_if #(.N(3)) bus1 ();

  sat_assignment_search #(.N(3), .LAT(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  sat_assignment_search #(.N(3), .LAT(2)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Evaluator models
  logic       sat_zero;
  logic [2:0] tgt0;
  logic       dly3;
  logic [2:0] hist = 3'b000;

  assign bus0.sat_in = !sat_zero && (bus0.assign_out == tgt0);
  always @(posedge clk) hist <= {hist[1:0], (bus1.assign_out == 3'd5)};
  assign bus1.sat_in = dly3 ? hist[2] : hist[1];

  // Scoreboard
  typedef struct {
    logic busy;
    logic done;
    logic found;
    int   ao;
    int   sol;
    int   tried;
    int   bcyc;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int d, input logic b, input logic dn, input logic f,
                           input int ao, input int sol, input int tr, input int bc);
    rec_t r;
    r.busy = b; r.done = dn; r.found = f;
    r.ao = ao; r.sol = sol; r.tried = tr; r.bcyc = bc;
    if (d == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  // Called at a negedge; holds the command over exactly one rising edge.
  task automatic cmd(input int d, input logic s, input logic n, input logic a);
    if (d == 0) begin bus0.start = s; bus0.next = n; bus0.abort = a; end
    else        begin bus1.start = s; bus1.next = n; bus1.abort = a; end
    @(posedge clk);
    @(negedge clk);
    if (d == 0) begin bus0.start = 0; bus0.next = 0; bus0.abort = 0; end
    else        begin bus1.start = 0; bus1.next = 0; bus1.abort = 0; end
  endtask

  task automatic drain(input int d, input string name);
    int k = 0;
    int left;
    left = (d == 0) ? q0.size() : q1.size();
    while (left != 0 && k < 400) begin
      @(negedge clk);
      k++;
      left = (d == 0) ? q0.size() : q1.size();
    end
    n_cmp++;
    if (left != 0) begin
      n_err++;
      $display("FAIL %s_timeout: %0d events still pending, required 0", name, left);
      if (d == 0) q0.delete();
      else        q1.delete();
    end
  endtask

  // Monitor
  logic [1:0] w_busy, w_done, w_found;
  logic [2:0] w_ao  [2];
  logic [2:0] w_sol [2];
  logic [3:0] w_tr  [2];
  assign w_busy  = {bus1.busy,  bus0.busy};
  assign w_done  = {bus1.done,  bus0.done};
  assign w_found = {bus1.found, bus0.found};
  assign w_ao[0]  = bus0.assign_out; assign w_ao[1]  = bus1.assign_out;
  assign w_sol[0] = bus0.solution;   assign w_sol[1] = bus1.solution;
  assign w_tr[0]  = bus0.tried;      assign w_tr[1]  = bus1.tried;

  logic [2:0] prev [2] = '{3'b000, 3'b000};
  int         bcyc [2] = '{0, 0};
  logic       mon_en = 1'b0;

  always @(negedge clk) begin : mon
    rec_t r;
    int   qs;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        if (!w_busy[d] && ({w_busy[d], w_done[d], w_found[d]} != prev[d])) begin
          qs = (d == 0) ? q0.size() : q1.size();
          if (qs == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL dut%0d_unexpected_event: got done=%0d found=%0d tried=%0d, required no event",
                     d, w_done[d], w_found[d], w_tr[d]);
          end else begin
            if (d == 0) r = q0.pop_front();
            else        r = q1.pop_front();
            chk($sformatf("dut%0d_busy", d),        w_busy[d],  r.busy);
            chk($sformatf("dut%0d_done", d),        w_done[d],  r.done);
            chk($sformatf("dut%0d_found", d),       w_found[d], r.found);
            chk($sformatf("dut%0d_assign_out", d),  w_ao[d],    r.ao);
            chk($sformatf("dut%0d_solution", d),    w_sol[d],   r.sol);
            chk($sformatf("dut%0d_tried", d),       w_tr[d],    r.tried);
            chk($sformatf("dut%0d_busy_cycles", d), bcyc[d],    r.bcyc);
          end
          bcyc[d] = 0;
        end else if (w_busy[d]) begin
          bcyc[d]++;
        end
        prev[d] = {w_busy[d], w_done[d], w_found[d]};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus0.start = 0; bus0.next = 0; bus0.abort = 0;
    bus1.start = 0; bus1.next = 0; bus1.abort = 0;
    sat_zero = 1'b0; tgt0 = 3'd5; dly3 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_outputs_dut0", {bus0.busy, bus0.done, bus0.found, bus0.assign_out, bus0.solution, bus0.tried}, 0);
    chk("rst_outputs_dut1", {bus1.busy, bus1.done, bus1.found, bus1.assign_out, bus1.solution, bus1.tried}, 0);
    mon_en = 1'b1;

    // Target 5; a second start during the search must be ignored.
    expect_ev(0, 0, 1, 1, 5, 5, 6, 6);
    cmd(0, 1, 0, 0);
    @(negedge clk);
    cmd(0, 1, 0, 0);
    drain(0, "target5");

    // next: candidates 6 and 7, then exhausted.
    expect_ev(0, 0, 1, 0, 0, 5, 8, 2);
    cmd(0, 0, 1, 0);
    drain(0, "next_to_exhausted");

    // next in EXHAUSTED is ignored (any event would be unexpected).
    cmd(0, 0, 1, 0);
    repeat (4) @(negedge clk);

    // Unsatisfiable formula: full sweep.
    sat_zero = 1'b1;
    expect_ev(0, 0, 1, 0, 0, 0, 8, 8);
    cmd(0, 1, 0, 0);
    drain(0, "unsat");

    // Target 7, then next at the last assignment.
    sat_zero = 1'b0;
    tgt0 = 3'd7;
    expect_ev(0, 0, 1, 1, 7, 7, 8, 8);
    cmd(0, 1, 0, 0);
    drain(0, "target7");
    expect_ev(0, 0, 1, 0, 0, 7, 8, 0);
    cmd(0, 0, 1, 0);
    drain(0, "next_at_max");

    // Abort after three candidates, then a clean restart.
    tgt0 = 3'd5;
    expect_ev(0, 0, 0, 0, 0, 0, 3, 4);
    cmd(0, 1, 0, 0);
    repeat (3) @(negedge clk);
    cmd(0, 0, 0, 1);
    drain(0, "abort");
    expect_ev(0, 0, 1, 1, 5, 5, 6, 6);
    cmd(0, 1, 0, 0);
    drain(0, "restart");

    // start and abort together from FOUND -> IDLE.
    expect_ev(0, 0, 0, 0, 0, 5, 6, 0);
    cmd(0, 1, 0, 1);
    drain(0, "start_abort");

    // Reset in the middle of a search.
    expect_ev(0, 0, 0, 0, 0, 0, 0, 3);
    cmd(0, 1, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drain(0, "reset_mid");

    // LAT=2 instance, evaluator delay matched.
    expect_ev(1, 0, 1, 1, 5, 5, 6, 18);
    cmd(1, 1, 0, 0);
    drain(1, "lat2_match");
    expect_ev(1, 0, 0, 0, 0, 5, 6, 0);
    cmd(1, 0, 0, 1);
    drain(1, "lat2_abort");
    repeat (4) @(negedge clk);

    // Evaluator one cycle slower than LAT: the sample sees the previous
    // candidate, so the hit is reported against candidate 6.
    dly3 = 1'b1;
    expect_ev(1, 0, 1, 1, 6, 6, 7, 21);
    cmd(1, 1, 0, 0);
    drain(1, "lat2_mismatch");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
